dino_jump_ctrl: RTL
===================

DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

Interface
REQ-001 SHALL have parameter GROUND_VPOS, default 4'd12, sprite top row when the dino stands on the ground.
REQ-002 SHALL have parameter JUMP_VEL, default 4, initial upward velocity in rows per frame (1..7).
REQ-003 SHALL have parameter GRAVITY, default 1, velocity decrement per frame (1..3).
REQ-004 SHALL have port clk  input  1  system clock; the block uses one clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_jump  input  1  raw jump button, asynchronous, active-high.
REQ-007 SHALL have port i_frame_tick  input  1  one-cycle pulse per video frame (end of vblank).
REQ-008 SHALL have port i_freeze  input  1  game-over/pause; holds all physics state.
REQ-009 SHALL have port o_dino_vpos  output  4  sprite top row, feeds the sprite layer i_dino_vpos.
REQ-010 SHALL have port o_airborne  output  1  high while the state is AIR.
REQ-011 SHALL have port o_land  output  1  one-cycle pulse on the landing cycle.

Function
REQ-012 SHALL synchronise i_jump through two flops and detect rising edges on the synchronised signal.
REQ-013 SHALL set a sticky jump_req on a detected edge while in GROUND and not frozen; edges in AIR or while frozen SHALL be dropped.
REQ-014 SHALL implement states GROUND and AIR; physics SHALL update only on cycles with i_frame_tick=1 and i_freeze=0.
REQ-015 In GROUND on an update with jump_req=1, the block SHALL set vel=JUMP_VEL, keep height=0, clear jump_req and enter AIR.
REQ-016 On an AIR update with vel>0, or with vel<=0 and height+vel>0, the block SHALL set height=height+vel and vel=vel-GRAVITY.
REQ-017 On an AIR update with vel<=0 and height+vel<=0, the block SHALL set height=0 and vel=0, enter GROUND, and pulse o_land for exactly one cycle.
REQ-018 Height SHALL be 5-bit unsigned, vel SHALL be 5-bit signed, and the sum SHALL be computed 6-bit signed; height SHALL clamp at GROUND_VPOS.
REQ-019 o_dino_vpos SHALL be registered and equal GROUND_VPOS-height, so one update produces a new value one cycle after the tick.
REQ-020 An edge coincident with the tick SHALL take effect on the next tick, since jump_req is sampled before it is set.
REQ-021 i_freeze=1 SHALL hold the state, height, vel and jump_req, and SHALL clear o_land.

Reset
REQ-022 While rst_n=0, the block SHALL force state=GROUND, height=0, vel=0, jump_req=0, sync flops=0, o_dino_vpos=GROUND_VPOS, o_airborne=0 and o_land=0, including when reset asserts mid-jump.
REQ-023 The first update after reset release SHALL see no spurious jump edge, even if i_jump is held high through reset.

Structure
REQ-024 The shared game package SHALL hold the state enum, the GROUND_VPOS/JUMP_VEL/GRAVITY defaults and the 4-bit vpos width constant.
REQ-025 The block SHALL contain one sub-module, button_sync_edge, holding the 2-flop synchroniser and rising-edge detector, which is reusable for a duck button.

Verification
REQ-026 Scenario: press once with defaults, then ticks -> o_dino_vpos sequence 12,8,5,3,2,2,3,5,8,12, with o_land on the 10th tick and o_airborne high for ticks 1-9.
REQ-027 Scenario: press during AIR -> ignored; after landing, a new tick without a new press -> stays at 12.
REQ-028 Scenario: press then i_freeze=1 over 5 ticks -> vpos held; release freeze -> sequence resumes exactly.
REQ-029 Scenario: rst_n low at tick 4 of a jump -> o_dino_vpos=12 and o_airborne=0 asynchronously; i_jump held high across release -> no jump.
REQ-030 Scenario: press coincident with tick -> takeoff on the following tick; two presses between ticks -> one jump.
REQ-031 Scenario: JUMP_VEL=7 and GRAVITY=1 -> height clamps at 12, giving o_dino_vpos minimum 0 with no wrap, and landing still reached.

Source files
------------

// File: rtl/dino_jump_ctrl_pkg.sv
// Shared game package for the dino jump controller.
// Holds the jump FSM state enum, the physics parameter defaults and the
// sprite vertical-position width.
package dino_jump_ctrl_pkg;

    localparam int unsigned VposW = 4;

    localparam logic [VposW-1:0] DefGroundVpos = 4'd12;
    localparam int unsigned      DefJumpVel    = 4;
    localparam int unsigned      DefGravity    = 1;

    typedef enum logic {
        StGround = 1'b0,
        StAir    = 1'b1
    } dino_state_e;

endpackage

// File: rtl/dino_jump_ctrl_if.sv
// Jump controller bus: game-side control inputs and sprite-side outputs.
//   i_jump       raw jump button (asynchronous)
//   i_frame_tick one-cycle pulse per video frame
//   i_freeze     game-over / pause, holds all physics state
//   o_dino_vpos  sprite top row
//   o_airborne   high while in the air
//   o_land       one-cycle pulse on landing
interface dino_jump_ctrl_if;
    import dino_jump_ctrl_pkg::*;

    logic             i_jump;
    logic             i_frame_tick;
    logic             i_freeze;
    logic [VposW-1:0] o_dino_vpos;
    logic             o_airborne;
    logic             o_land;

    // Game logic side
    modport master (
        output i_jump, i_frame_tick, i_freeze,
        input  o_dino_vpos, o_airborne, o_land
    );

    // Jump controller side
    modport slave (
        input  i_jump, i_frame_tick, i_freeze,
        output o_dino_vpos, o_airborne, o_land
    );

endinterface

// File: rtl/dino_jump_ctrl_button_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous button.
// Reusable for any game button (jump, duck).
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   i_btn   raw button level, asynchronous
//   o_rise  one-cycle pulse per rising edge of the synchronised level
module button_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_rise
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic [1:0] fill_q;

    // fill_q marks when sync2_q holds a real sample rather than its reset
    // value. prev_q starts high and only tracks sync2_q once that is true,
    // so a button held through reset never looks like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1]) begin
                prev_q <= sync2_q;
            end
        end
    end

    assign o_rise = sync2_q & ~prev_q & fill_q[1];

endmodule

// File: rtl/dino_jump_ctrl.sv
// Dino jump physics controller.
// A synchronised jump press arms a sticky request while grounded; on each
// unfrozen frame tick the GROUND/AIR FSM launches, integrates height and
// velocity, and lands when the next step would reach or pass the ground.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    dino_jump_ctrl_if.slave (jump/tick/freeze in, vpos/airborne/land out)
module dino_jump_ctrl
    import dino_jump_ctrl_pkg::*;
#(
    parameter logic [VposW-1:0] GROUND_VPOS = DefGroundVpos,
    parameter int unsigned      JUMP_VEL    = DefJumpVel,
    parameter int unsigned      GRAVITY     = DefGravity
) (
    input  logic             clk,
    input  logic             rst_n,
    dino_jump_ctrl_if.slave  bus
);

    localparam logic signed [4:0] JumpVelS   = 5'(JUMP_VEL);
    localparam logic signed [4:0] GravityS   = 5'(GRAVITY);
    localparam logic [4:0]        HeightMax  = {1'b0, GROUND_VPOS};
    localparam logic signed [5:0] HeightMaxS = {2'b00, GROUND_VPOS};

    dino_state_e       state_q, state_d;
    logic [4:0]        height_q, height_d;
    logic signed [4:0] vel_q, vel_d;
    logic              jump_req_q, jump_req_d;
    logic [VposW-1:0]  vpos_q, vpos_d;
    logic              land_q, land_d;

    logic              jump_rise;
    logic signed [5:0] sum;
    logic              vel_nonpos;
    logic              sum_nonpos;

    button_sync_edge u_jump_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (bus.i_jump),
        .o_rise (jump_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StGround;
            height_q   <= 5'd0;
            vel_q      <= 5'sd0;
            jump_req_q <= 1'b0;
            vpos_q     <= GROUND_VPOS;
            land_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            height_q   <= height_d;
            vel_q      <= vel_d;
            jump_req_q <= jump_req_d;
            vpos_q     <= vpos_d;
            land_q     <= land_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        height_d   = height_q;
        vel_d      = vel_q;
        jump_req_d = jump_req_q;
        land_d     = 1'b0;

        sum        = $signed({1'b0, height_q}) + $signed({vel_q[4], vel_q});
        vel_nonpos = vel_q[4] | (vel_q == 5'sd0);
        sum_nonpos = sum[5] | (sum == 6'sd0);

        if (!bus.i_freeze) begin
            if (jump_rise && (state_q == StGround)) begin
                jump_req_d = 1'b1;
            end

            // Takeoff below samples jump_req_q, so an edge on the tick
            // cycle itself only launches on the following tick.
            if (bus.i_frame_tick) begin
                unique case (state_q)
                    StGround: begin
                        if (jump_req_q) begin
                            vel_d      = JumpVelS;
                            height_d   = 5'd0;
                            jump_req_d = 1'b0;
                            state_d    = StAir;
                        end
                    end
                    StAir: begin
                        if (vel_nonpos && sum_nonpos) begin
                            height_d = 5'd0;
                            vel_d    = 5'sd0;
                            state_d  = StGround;
                            land_d   = 1'b1;
                        end else begin
                            // sum is positive here; clamp keeps vpos from wrapping
                            height_d = (sum > HeightMaxS) ? HeightMax : sum[4:0];
                            vel_d    = vel_q - GravityS;
                        end
                    end
                endcase
            end
        end

        vpos_d = GROUND_VPOS - height_d[VposW-1:0];
    end

    assign bus.o_dino_vpos = vpos_q;
    assign bus.o_airborne  = (state_q == StAir);
    assign bus.o_land      = land_q;

endmodule
